// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: opcodes, FSM state encoding and op-class helpers.
// Defining MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU opcodes.
package mdu_unit_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV
    } mdu_state_e;

    function automatic logic is_mult_op(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product, quotient/remainder and accumulate datapath for the MDU.
// Accumulate opcodes are only decoded when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo
);

    localparam int DW = DATA_WIDTH;

    logic signed [2*DW-1:0] sa, sb, prod_s;
    logic        [2*DW-1:0] prod_u, acc;
    logic signed [DW-1:0]   sdiv, sq, sr;
    logic        [DW-1:0]   udiv, uq, ur;
    logic                   div_zero, div_ovf;

    assign sa     = {{DW{a[DW-1]}}, a};
    assign sb     = {{DW{b[DW-1]}}, b};
    assign prod_s = sa * sb;
    assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign acc    = {hi, lo};

    // Divisor forced to 1 for /0 (result discarded) and MIN/-1 (gives q=MIN, r=0).
    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(DW-1){1'b0}}}) && (b == '1);
    assign sdiv     = (div_zero || div_ovf) ? DW'(1) : $signed(b);
    assign udiv     = div_zero ? DW'(1) : b;
    assign sq       = $signed(a) / sdiv;
    assign sr       = $signed(a) % sdiv;
    assign uq       = a / udiv;
    assign ur       = a % udiv;

    always_comb begin
        wr_en            = 1'b1;
        {res_hi, res_lo} = acc;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_hi = sr;
                res_lo = sq;
                wr_en  = !div_zero;
            end
            MDU_DIVU: begin
                res_hi = ur;
                res_lo = uq;
                wr_en  = !div_zero;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = acc + prod_s;
            MDU_MADDU: {res_hi, res_lo} = acc + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = acc - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
            default:   wr_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; FSM, latency counter and operand latches.
// MDU_MADD_EN enables multiply-accumulate opcodes (see mdu_unit_pkg).
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    input  logic                  read_hi,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e            state_q;
    logic [CNT_W-1:0]      count_q;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic [DATA_WIDTH-1:0] res_hi, res_lo;
    logic                  wr_en;

    mdu_arith #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .wr_en  (wr_en),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign rd_data = read_hi ? hi_q : lo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy    <= 1'b0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mult_op(op) || is_div_op(op)) begin
                            state_q <= is_mult_op(op) ? ST_MULT : ST_DIV;
                            count_q <= is_mult_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy    <= 1'b1;
                            op_q    <= op;
                            a_q     <= rs_val;
                            b_q     <= rt_val;
                        end else if (op == MDU_MTHI) begin
                            hi_q <= rs_val;
                        end else if (op == MDU_MTLO) begin
                            lo_q <= rs_val;
                        end
                    end
                end
                default: begin
                    // Any start while busy is ignored; only the counter matters here.
                    if (count_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                        busy    <= 1'b0;
                        if (wr_en) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random ops against an arithmetic model.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int DW = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          read_hi = 1'b0;
    logic [3:0]    op = MDU_NONE;
    logic [DW-1:0] rs_val = '0;
    logic [DW-1:0] rt_val = '0;
    logic [DW-1:0] rd_data;
    logic          busy;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_unit #(
        .DATA_WIDTH  (DW),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .read_hi (read_hi),
        .rd_data (rd_data),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs_exp(input string tag, input logic [DW-1:0] eh, input logic [DW-1:0] el);
        logic [DW-1:0] h, l;
        read_hi = 1'b1;
        #1 h = rd_data;
        read_hi = 1'b0;
        #1 l = rd_data;
        chk({tag, " hi"}, 64'(h), 64'(eh));
        chk({tag, " lo"}, 64'(l), 64'(el));
    endtask

    task automatic chk_regs(input string tag);
        chk_regs_exp(tag, m_hi, m_lo);
    endtask

    function automatic int latency(input logic [3:0] o);
        case (o)
            MDU_MULT, MDU_MULTU: return MC;
            MDU_DIV, MDU_DIVU:   return DC;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    // Reference: plain 64-bit integer arithmetic on the architectural HI/LO.
    task automatic model(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic [63:0]     acc = {m_hi, m_lo};
        logic [63:0]     r;
        logic [63:0]     q;
        case (o)
            MDU_MULT:  {m_hi, m_lo} = sa * sb;
            MDU_MULTU: {m_hi, m_lo} = ua * ub;
            MDU_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[DW-1:0];
                m_hi = r[DW-1:0];
            end
            MDU_DIVU: if (b != 0) begin
                q = ua / ub;
                r = ua % ub;
                m_lo = q[DW-1:0];
                m_hi = r[DW-1:0];
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  {m_hi, m_lo} = acc + 64'(sa * sb);
            MDU_MADDU: {m_hi, m_lo} = acc + 64'(ua * ub);
            MDU_MSUB:  {m_hi, m_lo} = acc - 64'(sa * sb);
            MDU_MSUBU: {m_hi, m_lo} = acc - 64'(ua * ub);
`endif
            default: ;
        endcase
    endtask

    // Launch one op, check busy and stale HI/LO for every in-flight cycle, then the result.
    task automatic do_op(input string tag, input logic [3:0] o,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = latency(o);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; rs_val = $urandom; rt_val = $urandom;
        for (int i = 1; i <= n; i++) begin
            chk({tag, " busy in flight"}, 64'(busy), 64'(1));
            chk_regs({tag, " old while busy"});
            @(negedge clk);
        end
        model(o, a, b);
        chk({tag, " busy done"}, 64'(busy), 64'(0));
        chk_regs(tag);
    endtask

    initial begin
        logic [3:0] rop;
        logic [DW-1:0] ra, rb;

        // Reset
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk_regs_exp("reset", '0, '0);

        // Multiply
        do_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'h2);
        chk_regs_exp("mult const", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
        chk_regs_exp("multu const", 32'h1, 32'hFFFF_FFFE);

        // Divide, including divide-by-zero and overflow
        do_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'h2);
        chk_regs_exp("div const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu by 0", MDU_DIVU, 32'h7, 32'h0);
        chk_regs_exp("divu0 const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_regs_exp("div ovf const", 32'h0, 32'h8000_0000);
        do_op("div by 0", MDU_DIV, 32'h1234, 32'h0);
        do_op("divu", MDU_DIVU, 32'hFFFF_FFF9, 32'h2);

        // Moves
        do_op("mthi", MDU_MTHI, 32'h1234, 32'h0);
        do_op("mtlo", MDU_MTLO, 32'h5678, 32'h0);
        chk_regs_exp("mthi/mtlo const", 32'h1234, 32'h5678);
        do_op("none", MDU_NONE, 32'hDEAD, 32'hBEEF);
        do_op("undef", 4'd14, 32'hDEAD, 32'hBEEF);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; rs_val = 32'h0001_0003; rt_val = 32'h7;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        chk("inject busy c1", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; rs_val = 32'h9; rt_val = 32'h3;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        chk("inject busy c3", 64'(busy), 64'(1));
        repeat (MC - 2) @(negedge clk);
        model(MDU_MULT, 32'h0001_0003, 32'h7);
        chk("inject busy done", 64'(busy), 64'(0));
        chk_regs("inject result");
        @(negedge clk);
        chk("inject no relaunch", 64'(busy), 64'(0));

        // Reset mid-op aborts and clears HI/LO
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; rs_val = 32'h55; rt_val = 32'h3;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("abort busy", 64'(busy), 64'(0));
        chk_regs("abort");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MC + 1) @(negedge clk);
        chk("abort stays idle", 64'(busy), 64'(0));
        chk_regs("abort after");

        // Accumulate ops (no effect when the feature is absent)
        do_op("mthi0", MDU_MTHI, 32'h0, 32'h0);
        do_op("mtlo ff", MDU_MTLO, 32'hFFFF_FFFF, 32'h0);
        do_op("maddu", MDU_MADDU, 32'h1, 32'h1);
`ifdef MDU_MADD_EN
        chk_regs_exp("maddu const", 32'h1, 32'h0);
`else
        chk_regs_exp("maddu const", 32'h0, 32'hFFFF_FFFF);
`endif
        do_op("msub", MDU_MSUB, 32'h3, 32'hFFFF_FFFE);

        // Random ops
        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            do_op("rand", rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
